// File: rtl/shift_rows_stream.sv
// shift_rows_stream: ShiftRows / InvShiftRows / bypass stage for Rijndael
// states of 4, 6 or 8 columns, followed by a 2-entry elastic buffer with
// a valid/ready handshake on both sides. Data is transformed on entry, so
// buffer entries already hold the result words.
module shift_rows_stream #(
    parameter int NB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:32*NB-1] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:32*NB-1] out_data,
    output logic [1:0]       out_mode,
    output logic             out_err,
    output logic [1:0]       level
);

    localparam int W = 32 * NB;

    generate
        if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
            $error("shift_rows_stream: NB must be 4, 6 or 8");
        end
    endgenerate

    // Row rotation amount; the 8-column Rijndael variant shifts rows 2 and 3
    // one column further than the 4/6-column variants.
    function automatic int f_row_shift(input int row);
        int s;
        if (NB == 8 && row >= 2) begin
            s = row + 1;
        end else begin
            s = row;
        end
        return s;
    endfunction

    // Byte permutation selected by mode; only the column index wraps.
    function automatic logic [0:W-1] f_transform(input logic [0:W-1] d,
                                                 input logic [1:0]   m);
        logic [0:W-1] o;
        int           src;
        o = d;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                case (m)
                    2'b00:   src = (c + f_row_shift(r)) % NB;
                    2'b01:   src = (c + NB - f_row_shift(r)) % NB;
                    default: src = c;
                endcase
                o[8*(4*c+r) +: 8] = d[8*(4*src+r) +: 8];
            end
        end
        return o;
    endfunction

    logic [1:0]   r_level;
    logic [0:W-1] r_head_data;
    logic [1:0]   r_head_mode;
    logic         r_head_err;
    logic [0:W-1] r_tail_data;
    logic [1:0]   r_tail_mode;
    logic         r_tail_err;

    logic [0:W-1] w_xform;
    logic         w_err;
    logic         w_push;
    logic         w_pop;

    // Transform the incoming word and flag the reserved mode.
    always_comb begin
        w_xform = f_transform(in_data, in_mode);
        if (in_mode == 2'b11) begin
            w_err = 1'b1;
        end else begin
            w_err = 1'b0;
        end
    end

    // Acceptance depends only on registered occupancy, never on out_ready.
    assign in_ready  = rst & (r_level != 2'd2);
    assign out_valid = (r_level != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign out_data  = r_head_data;
    assign out_mode  = r_head_mode;
    assign out_err   = r_head_err;
    assign level     = r_level;

    // Two-entry FIFO: head drives the outputs, tail holds the second word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_level     <= 2'd0;
            r_head_data <= '0;
            r_head_mode <= 2'b00;
            r_head_err  <= 1'b0;
            r_tail_data <= '0;
            r_tail_mode <= 2'b00;
            r_tail_err  <= 1'b0;
        end else begin
            case (r_level)
                2'd0: begin
                    if (w_push) begin
                        r_head_data <= w_xform;
                        r_head_mode <= in_mode;
                        r_head_err  <= w_err;
                        r_level     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head_data <= w_xform;
                        r_head_mode <= in_mode;
                        r_head_err  <= w_err;
                    end else if (w_push) begin
                        r_tail_data <= w_xform;
                        r_tail_mode <= in_mode;
                        r_tail_err  <= w_err;
                        r_level     <= 2'd2;
                    end else if (w_pop) begin
                        r_level     <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head_data <= r_tail_data;
                        r_head_mode <= r_tail_mode;
                        r_head_err  <= r_tail_err;
                        r_level     <= 2'd1;
                    end
                end
                default: begin
                    r_level <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Testbench for shift_rows_stream: NB=4 instance exercised fully against a
// queue-based reference, NB=8 and NB=6 instances checked for transform
// correctness and forward/inverse round trips.
module tb_shift_rows_stream;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // NB = 4 instance
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
    logic [0:127] in_data = '0, out_data;
    logic [1:0]   in_mode = 2'b00, out_mode, level;

    // NB = 8 instance
    logic         v8 = 1'b0, r8, ov8, ordy8 = 1'b1, oe8;
    logic [0:255] d8 = '0, od8;
    logic [1:0]   m8 = 2'b00, om8, lv8;

    // NB = 6 instance
    logic         v6 = 1'b0, r6, ov6, ordy6 = 1'b1, oe6;
    logic [0:191] d6 = '0, od6;
    logic [1:0]   m6 = 2'b00, om6, lv6;

    shift_rows_stream #(.NB(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
        .out_err(out_err), .level(level));

    shift_rows_stream #(.NB(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
        .in_data(d8), .in_mode(m8), .out_valid(ov8),
        .out_ready(ordy8), .out_data(od8), .out_mode(om8),
        .out_err(oe8), .level(lv8));

    shift_rows_stream #(.NB(6)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(v6), .in_ready(r6),
        .in_data(d6), .in_mode(m6), .out_valid(ov6),
        .out_ready(ordy6), .out_data(od6), .out_mode(om6),
        .out_err(oe6), .level(lv6));

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [0:127] d;
        logic [1:0]   m;
        logic         e;
    } item_t;
    item_t mq[$];

    // Reference: state as a 4 x nb byte matrix, rows rotated by table offsets.
    function automatic logic [0:255] ref_shift(input logic [0:255] d, input int nb,
                                               input logic [1:0] m);
        logic [7:0]   st[4][8];
        logic [0:255] o;
        int           off46[4] = '{0, 1, 2, 3};
        int           off8[4]  = '{0, 1, 3, 4};
        int           sh;
        o = d;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = d[8*(4*c+r) +: 8];
        if (m == 2'b00 || m == 2'b01) begin
            for (int r = 0; r < 4; r++) begin
                sh = (nb == 8) ? off8[r] : off46[r];
                if (m == 2'b01) sh = nb - sh;
                for (int c = 0; c < nb; c++)
                    o[8*(4*c+r) +: 8] = st[r][(c + sh) % nb];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] f4(input logic [0:127] x, input logic [1:0] m);
        logic [0:255] t;
        t = '0;
        t[0:127] = x;
        t = ref_shift(t, 4, m);
        return t[0:127];
    endfunction

    function automatic logic [0:191] f6(input logic [0:191] x, input logic [1:0] m);
        logic [0:255] t;
        t = '0;
        t[0:191] = x;
        t = ref_shift(t, 6, m);
        return t[0:191];
    endfunction

    // One clock on the NB=4 instance; the model queue tracks acceptance.
    task automatic cyc4(input logic v, input logic [0:127] d, input logic [1:0] m,
                        input logic ordy);
        item_t it;
        bit    push, pop;
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = ordy;
        push = v && rst && (mq.size() < 2);
        pop  = rst && (mq.size() > 0) && ordy;
        it.d = f4(d, m);
        it.m = m;
        it.e = (m == 2'b11);
        @(posedge clk);
        #1;
        if (!rst) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(it);
        end
    endtask

    task automatic test_reset();
        cyc4(1'b1, 128'h0123456789abcdef0123456789abcdef, 2'b00, 1'b0);
        cyc4(1'b0, '0, 2'b00, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || level !== 2'd0 || out_data !== 128'h0 ||
            out_mode !== 2'b00 || out_err !== 1'b0 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: valid=%b level=%0d data=%h mode=%b err=%b rdy=%b, required 0 0 0 0 0 0",
                     out_valid, level, out_data, out_mode, out_err, in_ready);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_fips();
        cyc4(1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 2'b00, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 128'hd4bf5d30e0b452aeb84111f11e2798e5 ||
            out_err !== 1'b0 || out_mode !== 2'b00) begin
            n_errors++;
            $display("FAIL fips_forward: valid=%b data=%h err=%b, required 1 d4bf5d30e0b452aeb84111f11e2798e5 0",
                     out_valid, out_data, out_err);
        end
        cyc4(1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 2'b01, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 128'hd42711aee0bf98f1b8b45de51e415230 ||
            out_mode !== 2'b01 || level !== 2'd1) begin
            n_errors++;
            $display("FAIL fips_inverse: valid=%b data=%h mode=%b level=%0d, required 1 d42711aee0bf98f1b8b45de51e415230 01 1",
                     out_valid, out_data, out_mode, level);
        end
        cyc4(1'b0, '0, 2'b00, 1'b1);
    endtask

    task automatic test_roundtrip4();
        logic [0:127] w, fw;
        int           bad = 0;
        for (int i = 0; i < 1000; i++) begin
            w  = {$urandom(), $urandom(), $urandom(), $urandom()};
            fw = f4(w, 2'b00);
            cyc4(1'b1, w, 2'b00, 1'b1);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== fw) begin
                n_errors++;
                if (bad++ < 5) $display("FAIL rt4_forward[%0d]: got %h required %h", i, out_data, fw);
            end
            cyc4(1'b1, out_data, 2'b01, 1'b1);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== w) begin
                n_errors++;
                if (bad++ < 5) $display("FAIL rt4_inverse[%0d]: got %h required %h", i, out_data, w);
            end
        end
        cyc4(1'b0, '0, 2'b00, 1'b1);
    endtask

    task automatic test_bypass_reserved();
        logic [0:127] w;
        logic [1:0]   modes[3] = '{2'b10, 2'b11, 2'b00};
        for (int i = 0; i < 3; i++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            cyc4(1'b1, w, modes[i], 1'b1);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== mq[0].d || out_mode !== modes[i] ||
                out_err !== (modes[i] == 2'b11)) begin
                n_errors++;
                $display("FAIL bypass_mode%b: data=%h mode=%b err=%b, required %h %b %b",
                         modes[i], out_data, out_mode, out_err, mq[0].d, modes[i], modes[i] == 2'b11);
            end
            if (modes[i] != 2'b00) begin
                n_checks++;
                if (out_data !== w) begin
                    n_errors++;
                    $display("FAIL bypass_identity%b: got %h required %h", modes[i], out_data, w);
                end
            end
        end
        cyc4(1'b0, '0, 2'b00, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [0:127] w0, w1, w2;
        w0 = {$urandom(), $urandom(), $urandom(), $urandom()};
        w1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        w2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        cyc4(1'b1, w0, 2'b00, 1'b0);
        n_checks++;
        if (level !== 2'd1 || in_ready !== 1'b1 || out_data !== f4(w0, 2'b00)) begin
            n_errors++;
            $display("FAIL bp_first: level=%0d rdy=%b data=%h, required 1 1 %h", level, in_ready, out_data, f4(w0, 2'b00));
        end
        cyc4(1'b1, w1, 2'b01, 1'b0);
        n_checks++;
        if (level !== 2'd2 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_full: level=%0d rdy=%b, required 2 0", level, in_ready);
        end
        cyc4(1'b1, w2, 2'b10, 1'b0);
        n_checks++;
        if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== f4(w0, 2'b00) || mq.size() != 2) begin
            n_errors++;
            $display("FAIL bp_hold: level=%0d rdy=%b data=%h, required 2 0 %h", level, in_ready, out_data, f4(w0, 2'b00));
        end
        cyc4(1'b1, w2, 2'b10, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || level !== 2'd1 || in_ready !== 1'b1 ||
            out_data !== f4(w1, 2'b01) || out_mode !== 2'b01) begin
            n_errors++;
            $display("FAIL bp_release1: valid=%b level=%0d rdy=%b data=%h, required 1 1 1 %h",
                     out_valid, level, in_ready, out_data, f4(w1, 2'b01));
        end
        cyc4(1'b1, w2, 2'b10, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || level !== 2'd1 || out_data !== w2 || out_mode !== 2'b10) begin
            n_errors++;
            $display("FAIL bp_release2: valid=%b level=%0d data=%h mode=%b, required 1 1 %h 10",
                     out_valid, level, out_data, out_mode, w2);
        end
        cyc4(1'b0, '0, 2'b00, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || level !== 2'd0) begin
            n_errors++;
            $display("FAIL bp_drained: valid=%b level=%0d, required 0 0", out_valid, level);
        end
    endtask

    task automatic test_reset_mid();
        logic [0:127] a, e;
        a = {$urandom(), $urandom(), $urandom(), $urandom()};
        e = {$urandom(), $urandom(), $urandom(), $urandom()};
        cyc4(1'b1, a, 2'b00, 1'b0);
        cyc4(1'b1, ~a, 2'b01, 1'b0);
        n_checks++;
        if (level !== 2'd2) begin
            n_errors++;
            $display("FAIL rst_mid_fill: level=%0d required 2", level);
        end
        rst = 1'b0;
        cyc4(1'b1, e, 2'b00, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || level !== 2'd0 || out_data !== 128'h0 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_clear: valid=%b level=%0d data=%h rdy=%b, required 0 0 0 0",
                     out_valid, level, out_data, in_ready);
        end
        rst = 1'b1;
        #1;
        cyc4(1'b1, e, 2'b01, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || level !== 2'd1 || out_data !== f4(e, 2'b01)) begin
            n_errors++;
            $display("FAIL rst_mid_first: valid=%b level=%0d data=%h, required 1 1 %h",
                     out_valid, level, out_data, f4(e, 2'b01));
        end
        cyc4(1'b0, '0, 2'b00, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || level !== 2'd0) begin
            n_errors++;
            $display("FAIL rst_mid_no_stale: valid=%b level=%0d, required 0 0", out_valid, level);
        end
    endtask

    task automatic test_nb8();
        logic [0:255] d, f;
        for (int k = 0; k < 32; k++) d[8*k +: 8] = 8'(k);
        v8 = 1'b1; d8 = d; m8 = 2'b00; ordy8 = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ov8 !== 1'b1 || od8[0:31] !== 32'h00050e13 || od8[32:63] !== 32'h04091217 ||
            od8 !== ref_shift(d, 8, 2'b00) || oe8 !== 1'b0 || om8 !== 2'b00 || lv8 !== 2'd1) begin
            n_errors++;
            $display("FAIL nb8_ramp: valid=%b data=%h, required 1 %h", ov8, od8, ref_shift(d, 8, 2'b00));
        end
        for (int i = 0; i < 40; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
            d8 = d; m8 = 2'b00;
            @(posedge clk); #1;
            f = od8;
            n_checks++;
            if (f !== ref_shift(d, 8, 2'b00) || r8 !== 1'b1) begin
                n_errors++;
                $display("FAIL nb8_forward[%0d]: got %h required %h", i, f, ref_shift(d, 8, 2'b00));
            end
            d8 = f; m8 = 2'b01;
            @(posedge clk); #1;
            n_checks++;
            if (od8 !== d) begin
                n_errors++;
                $display("FAIL nb8_roundtrip[%0d]: got %h required %h", i, od8, d);
            end
        end
        v8 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nb6();
        logic [0:191] d, f;
        v6 = 1'b1; ordy6 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            d6 = d; m6 = 2'b00;
            @(posedge clk); #1;
            f = od6;
            n_checks++;
            if (ov6 !== 1'b1 || f !== f6(d, 2'b00) || r6 !== 1'b1 || lv6 !== 2'd1) begin
                n_errors++;
                $display("FAIL nb6_forward[%0d]: got %h required %h", i, f, f6(d, 2'b00));
            end
            d6 = f; m6 = 2'b01;
            @(posedge clk); #1;
            n_checks++;
            if (od6 !== d || om6 !== 2'b01 || oe6 !== 1'b0) begin
                n_errors++;
                $display("FAIL nb6_roundtrip[%0d]: got %h required %h", i, od6, d);
            end
        end
        v6 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_fips();
        test_roundtrip4();
        test_bypass_reserved();
        test_backpressure();
        test_reset_mid();
        test_nb8();
        test_nb6();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_rows_stream.md
# shift_rows_stream

Parametrised, flow-controlled ShiftRows / InvShiftRows stage for the AES/Rijndael datapath. It supports Rijndael block widths of NB = 4, 6 or 8 columns and selects forward, inverse or bypass per word. A 2-entry elastic output buffer carries a valid/ready handshake on both sides. It sits between SubBytes and MixColumns in the round pipeline and replaces the fixed 128-bit, enable/done style stage.

## Interface
- NB, 4, number of state columns; legal values 4, 6, 8; any other value fails elaboration
- W, 32*NB (derived, not overridable), data width in bits
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-low (0 at a posedge of clk resets)
- in_valid  in  1  upstream word present
- in_ready  out  1  stage can accept a word this cycle
- in_data  in  [0:W-1]  state, column-major: byte k at bits [8k +: 8], row k%4, column k/4
- in_mode  in  2  00 forward ShiftRows, 01 InvShiftRows, 10 bypass, 11 reserved
- out_valid  out  1  head-of-buffer word valid
- out_ready  in  1  downstream accepts head word
- out_data  out  [0:W-1]  transformed state, same layout as in_data
- out_mode  out  2  in_mode captured with the word
- out_err  out  1  word was submitted with reserved mode 11
- level  out  2  buffer occupancy, 0..2

## Operation
- Row shift offsets s_r, for r = 0..3:
  - NB = 4 or 6: 0, 1, 2, 3
  - NB = 8: 0, 1, 3, 4
- Transform, byte-wise; modulo arithmetic on column index only:
  - forward: out[r][c] = in[r][(c + s_r) mod NB]
  - inverse: out[r][c] = in[r][(c - s_r) mod NB]
  - bypass and reserved: out = in
- Reserved mode 11: data passes through unchanged, out_err = 1 for that word only, out_mode = 11. The word is still delivered; it is never dropped.
- Transform is applied before storage. Buffer entries hold transformed data, mode and err.
- Buffer is a 2-entry FIFO. State is encoded by level:
  - EMPTY (0): push -> ONE
  - ONE (1): push only -> FULL; pop only -> EMPTY; push and pop together -> ONE
  - FULL (2): pop -> ONE; push is impossible (in_ready = 0)
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = rst & (level != 2). It depends only on registered state, with no combinational path from out_ready.
- out_valid = (level != 0).
- out_data, out_mode and out_err come from the head entry, are register-driven and stay stable while out_valid & !out_ready.
- Words leave in acceptance order. No reordering, no loss, no duplication.

## Timing
- Reset (rst = 0 at a posedge): level = 0, out_valid = 0, out_data = 0, out_mode = 00, out_err = 0, storage cleared. in_ready = 0 while rst = 0.
- Reset mid-operation discards all buffered words. in_valid in the reset cycle is ignored. in_ready = 1 in the first cycle with rst = 1.
- Latency: a word accepted at edge N is on out_data with out_valid = 1 after edge N, so it is visible in cycle N+1.
- Throughput: 1 word/cycle sustained while out_ready = 1. The buffer stays at level 1 with simultaneous push and pop.
- Backpressure: with out_ready = 0, two words are absorbed, then in_ready drops the cycle after the second push. The first pop re-asserts in_ready one cycle later.
- Upstream may change in_data or in_mode freely when in_ready = 0; nothing is sampled.

## Test plan
- NB=4, mode 00, in_data = d42711aee0bf98f1b8b45de51e415230 -> out_data = d4bf5d30e0b452aeb84111f11e2798e5 one cycle later, out_err = 0.
- NB=4, mode 01, in_data = d4bf5d30e0b452aeb84111f11e2798e5 -> out_data = d42711aee0bf98f1b8b45de51e415230. Also forward then inverse on 1000 random words returns the original.
- NB=8, mode 00, byte k = k (00..1f) -> column 0 = 00 05 0e 13, column 1 = 04 09 12 17. NB=6: random forward/inverse round-trip is identity.
- Mode 10 and 11 with random data -> out_data = in_data. out_err = 1 only on the 11 word, out_mode echoed.
- Backpressure: out_ready = 0 while 3 words are offered back-to-back -> 2 accepted, level = 2, in_ready = 0, third held. Release out_ready -> all 3 emerge in order, no gaps once streaming.
- Reset with level = 2 -> next cycle out_valid = 0, level = 0, out_data = 0. The first word after reset emerges correctly, and no stale word is emitted.
